// File: rtl/lockbox_seq_if.sv
// Keypad/character-buffer side of the lock-box sequencer: key strobes and buffer
// contents in, lock state, counters and buffer controls out.
interface lockbox_seq_if;
    logic        key_strobe;
    logic [4:0]  key_code;
    logic [31:0] buf_data;
    logic        buf_empty;
    logic [2:0]  state;
    logic [1:0]  fail_cnt;
    logic [5:0]  timer_sec;
    logic        buf_en;
    logic        buf_clr;

    modport master (
        output key_strobe, key_code, buf_data, buf_empty,
        input  state, fail_cnt, timer_sec, buf_en, buf_clr
    );

    modport slave (
        input  key_strobe, key_code, buf_data, buf_empty,
        output state, fail_cnt, timer_sec, buf_en, buf_clr
    );
endinterface

// File: rtl/lockbox_seq.sv
// Lock-box sequencing controller: owns the passphrase, the lock FSM, failed-attempt
// counting, the timed lockout and the OPEN auto-relock countdown.
module lockbox_seq #(
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCKOUT_S   = 10,
    parameter int unsigned RELOCK_S    = 30,
    parameter int unsigned TICKS_PER_S = 100
) (
    input  logic          hz100,
    input  logic          reset,
    lockbox_seq_if.slave  bus_io
);

    localparam int unsigned PrescW = $clog2(TICKS_PER_S);

    typedef enum logic [2:0] {
        StInit    = 3'd0,
        StSecure  = 3'd1,
        StOpen    = 3'd2,
        StAlarm   = 3'd3,
        StLockout = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         pass_q, pass_d;
    logic [1:0]          fail_q, fail_d;
    logic [PrescW-1:0]   presc_q, presc_d;
    logic [5:0]          timer_q, timer_d;
    logic                clr_q, clr_d;

    logic        key_w, key_y, pass_we, counting, wrap, expire;
    logic [31:0] data_eff;

    assign key_w    = bus_io.key_strobe && (bus_io.key_code == 5'd16);
    assign key_y    = bus_io.key_strobe && (bus_io.key_code == 5'd18);
    // An empty buffer compares as all-zero digits.
    assign data_eff = bus_io.buf_empty ? 32'd0 : bus_io.buf_data;
    assign counting = (state_q == StOpen) || (state_q == StLockout);
    assign wrap     = (presc_q == PrescW'(TICKS_PER_S - 1));
    assign expire   = counting && wrap && (timer_q == 6'd1);

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        presc_d = '0;
        timer_d = timer_q;
        pass_we = 1'b0;

        if (counting) begin
            if (wrap) begin
                timer_d = timer_q - 6'd1;
            end else begin
                presc_d = presc_q + PrescW'(1);
            end
        end

        unique case (state_q)
            StInit: begin
                if (key_w && !bus_io.buf_empty) begin
                    pass_we = 1'b1;
                    state_d = StSecure;
                end
            end
            StSecure: begin
                if (key_w) begin
                    if (data_eff == pass_q) begin
                        state_d = StOpen;
                        fail_d  = 2'd0;
                        timer_d = 6'(RELOCK_S);
                        presc_d = '0;
                    end else begin
                        fail_d = fail_q + 2'd1;
                        if (({30'd0, fail_q} + 32'd1) < MAX_TRIES) begin
                            state_d = StLockout;
                            timer_d = 6'(LOCKOUT_S);
                            presc_d = '0;
                        end else begin
                            state_d = StAlarm;
                            timer_d = 6'd0;
                        end
                    end
                end
            end
            StOpen: begin
                if (expire) begin
                    state_d = StSecure;
                    timer_d = 6'd0;
                end
                // A strobe on the expiry cycle overrides the relock.
                if (bus_io.key_strobe) begin
                    state_d = StOpen;
                    timer_d = 6'(RELOCK_S);
                    presc_d = '0;
                    if (key_y) begin
                        state_d = StSecure;
                        timer_d = 6'd0;
                    end else if (key_w && !bus_io.buf_empty) begin
                        pass_we = 1'b1;
                    end
                end
            end
            StLockout: begin
                if (expire) begin
                    state_d = StSecure;
                    timer_d = 6'd0;
                end
            end
            StAlarm: begin
                timer_d = 6'd0;
            end
            default: begin
                state_d = StInit;
                timer_d = 6'd0;
            end
        endcase

        if (pass_we) begin
            pass_d = bus_io.buf_data;
        end
        clr_d = (state_d != state_q) || pass_we;
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q <= StInit;
            pass_q  <= 32'd0;
            fail_q  <= 2'd0;
            presc_q <= '0;
            timer_q <= 6'd0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            clr_q   <= clr_d;
        end
    end

    assign bus_io.state     = state_q;
    assign bus_io.fail_cnt  = fail_q;
    assign bus_io.timer_sec = timer_q;
    assign bus_io.buf_clr   = clr_q;
    assign bus_io.buf_en    = (state_q == StInit) || (state_q == StSecure) ||
                              (state_q == StOpen);

endmodule

// File: tb/tb_lockbox_seq.sv
// Directed bench for lockbox_seq: each step queues its expected post-edge outputs
// and checks them against the DUT just after the edge.
module tb_lockbox_seq;

    localparam logic [4:0] KW = 5'd16;
    localparam logic [4:0] KX = 5'd17;
    localparam logic [4:0] KY = 5'd18;
    localparam logic [4:0] KZ = 5'd19;

    typedef struct {
        logic [2:0] st;
        logic [1:0] fc;
        logic [5:0] tm;
        logic       en;
        logic       clr;
    } exp_t;

    logic hz100 = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t  sb_q[$];
    string tag_q[$];

    lockbox_seq_if bus ();

    lockbox_seq #(
        .MAX_TRIES   (3),
        .LOCKOUT_S   (2),
        .RELOCK_S    (3),
        .TICKS_PER_S (4)
    ) dut (
        .hz100  (hz100),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 hz100 = ~hz100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic stb, input logic [4:0] code, input logic [31:0] data,
                        input logic emp, input logic [2:0] st, input logic [1:0] fc,
                        input logic [5:0] tm, input logic en, input logic clr,
                        input string tag);
        exp_t  e;
        string t;
        bus.key_strobe = stb;
        bus.key_code   = code;
        bus.buf_data   = data;
        bus.buf_empty  = emp;
        e = '{st: st, fc: fc, tm: tm, en: en, clr: clr};
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge hz100);
        #1;
        bus.key_strobe = 1'b0;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".state"},     32'(bus.state),     32'(e.st));
        chk({t, ".fail_cnt"},  32'(bus.fail_cnt),  32'(e.fc));
        chk({t, ".timer_sec"}, 32'(bus.timer_sec), 32'(e.tm));
        chk({t, ".buf_en"},    32'(bus.buf_en),    32'(e.en));
        chk({t, ".buf_clr"},   32'(bus.buf_clr),   32'(e.clr));
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            bus.key_strobe = 1'b0;
            @(posedge hz100);
            #1;
        end
    endtask

    initial begin
        bus.key_strobe = 1'b0;
        bus.key_code   = 5'd0;
        bus.buf_data   = 32'd0;
        bus.buf_empty  = 1'b1;

        reset = 1'b1;
        step(0, 5'd0, 32'h0, 1, 3'd0, 2'd0, 6'd0, 1, 0, "reset");
        reset = 1'b0;

        step(1, KW,   32'h1234, 1, 3'd0, 2'd0, 6'd0, 1, 0, "empty_w");
        step(1, 5'd5, 32'h1234, 0, 3'd0, 2'd0, 6'd0, 1, 0, "init_digit");
        step(1, KW,   32'h1234, 0, 3'd1, 2'd0, 6'd0, 1, 1, "set_code");
        step(0, 5'd0, 32'h1234, 0, 3'd1, 2'd0, 6'd0, 1, 0, "clr_one_cycle");
        step(1, KW,   32'h1234, 0, 3'd2, 2'd0, 6'd3, 1, 1, "open");

        // Relock timing: first second, digit reload at cycle 11, then idle relock.
        quiet(3);
        step(0, 5'd0, 32'h0, 1, 3'd2, 2'd0, 6'd2, 1, 0, "open_tick");
        quiet(6);
        step(1, 5'd7, 32'h0, 1, 3'd2, 2'd0, 6'd3, 1, 0, "reload");
        quiet(10);
        step(0, 5'd0, 32'h0, 1, 3'd2, 2'd0, 6'd1, 1, 0, "pre_relock");
        step(0, 5'd0, 32'h0, 1, 3'd1, 2'd0, 6'd0, 1, 1, "relock");

        // Code change, Y lock, old code fails into lockout.
        step(1, KW, 32'h1234, 0, 3'd2, 2'd0, 6'd3, 1, 1, "reopen");
        step(1, KW, 32'h55,   0, 3'd2, 2'd0, 6'd3, 1, 1, "code_change");
        step(1, KY, 32'h0,    1, 3'd1, 2'd0, 6'd0, 1, 1, "lock_y");
        step(1, KW, 32'h1234, 0, 3'd4, 2'd1, 6'd2, 0, 1, "old_fail");
        step(1, KW, 32'h55,   0, 3'd4, 2'd1, 6'd2, 0, 0, "lockout_ignore");
        quiet(5);
        step(0, 5'd0, 32'h0, 1, 3'd4, 2'd1, 6'd1, 0, 0, "pre_exit");
        step(0, 5'd0, 32'h0, 1, 3'd1, 2'd1, 6'd0, 1, 1, "lockout_exit");
        step(1, KZ, 32'h55, 0, 3'd1, 2'd1, 6'd0, 1, 0, "z_ignored");
        step(1, KX, 32'h55, 0, 3'd1, 2'd1, 6'd0, 1, 0, "x_ignored");
        step(1, KW, 32'h55, 0, 3'd2, 2'd0, 6'd3, 1, 1, "new_code_open");
        quiet(11);
        step(1, 5'd3, 32'h0, 1, 3'd2, 2'd0, 6'd3, 1, 0, "expiry_tie");
        step(1, KY,   32'h0, 1, 3'd1, 2'd0, 6'd0, 1, 1, "lock_y2");

        // Three wrong compares end in alarm.
        step(1, KW, 32'h9999, 0, 3'd4, 2'd1, 6'd2, 0, 1, "wrong1");
        quiet(7);
        step(0, 5'd0, 32'h0, 1, 3'd1, 2'd1, 6'd0, 1, 1, "exit1");
        step(1, KW, 32'h9999, 0, 3'd4, 2'd2, 6'd2, 0, 1, "wrong2");
        quiet(7);
        step(0, 5'd0, 32'h0, 1, 3'd1, 2'd2, 6'd0, 1, 1, "exit2");
        step(1, KW, 32'h0,    1, 3'd3, 2'd3, 6'd0, 0, 1, "alarm");
        step(1, KW, 32'h55,   0, 3'd3, 2'd3, 6'd0, 0, 0, "alarm_hold");
        reset = 1'b1;
        step(0, 5'd0, 32'h0, 1, 3'd0, 2'd0, 6'd0, 1, 0, "alarm_reset");
        reset = 1'b0;

        // Reset mid-lockout overrides a coincident strobe.
        step(1, KW, 32'h1234, 0, 3'd1, 2'd0, 6'd0, 1, 1, "mid_set");
        step(1, KW, 32'h9999, 0, 3'd4, 2'd1, 6'd2, 0, 1, "mid_fail");
        quiet(3);
        reset = 1'b1;
        step(1, KW, 32'h1234, 0, 3'd0, 2'd0, 6'd0, 1, 0, "mid_reset");
        reset = 1'b0;
        step(0, 5'd0, 32'h0, 1, 3'd0, 2'd0, 6'd0, 1, 0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lockbox_seq.md
# lockbox_seq

Sequencing controller for the lock-box keypad datapath, running in the `hz100` domain between the key synchroniser and the character buffer. It decodes key strobes and owns the passphrase register and the lock state machine. It gates and clears the character buffer, counts failed attempts and enforces a timed lockout and an auto-relock timeout. Its state code drives the RGB indicators and seven-segment message selection in `top`.

## Interface
Parameters:
- `MAX_TRIES`, 3: failed compares before permanent alarm (2..3).
- `LOCKOUT_S`, 10: lockout duration in seconds (1..63).
- `RELOCK_S`, 30: idle seconds in OPEN before auto-relock (1..63).
- `TICKS_PER_S`, 100: `hz100` cycles per second (>=2).

Ports:
- `hz100` in 1: sole clock. Everything is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `key_strobe` in 1: one-cycle pulse per debounced key press.
- `key_code` in 5: code of the pressed key, valid when `key_strobe`=1.
  - 0–15: digits.
  - 16: W (enter).
  - 17: X (backspace).
  - 18: Y (lock).
  - 19: Z (ignored).
- `buf_data` in 32: current character-buffer contents, 8 nibbles.
- `buf_empty` in 1: character buffer holds no characters.
- `state` out 3: lock state. 0 INIT, 1 SECURE, 2 OPEN, 3 ALARM, 4 LOCKOUT.
- `fail_cnt` out 2: consecutive failed compares.
- `timer_sec` out 6: seconds remaining in LOCKOUT or OPEN; 0 otherwise.
- `buf_en` out 1: character buffer may accept digits and backspace.
- `buf_clr` out 1: one-cycle clear pulse to the character buffer.

## Operation
- Registers:
  - state.
  - 32-bit passphrase.
  - `fail_cnt`.
  - prescaler, 0..TICKS_PER_S-1.
  - `timer_sec`.
  - `buf_clr`.
- Reset values:
  - `state`=INIT, passphrase=0, `fail_cnt`=0.
  - prescaler=0, `timer_sec`=0.
  - `buf_en`=1, `buf_clr`=0.
- `buf_en` is combinational from state: 1 in INIT, SECURE and OPEN; 0 in ALARM and LOCKOUT.
- `buf_clr` pulses whenever state changes or the passphrase is written.
- INIT:
  - W with `buf_empty`=0: passphrase<=`buf_data`, go to SECURE.
  - W with `buf_empty`=1: ignored.
  - Other keys: no action.
- SECURE, on W:
  - `buf_data`==passphrase: go to OPEN, `fail_cnt`<=0, load `timer_sec`<=RELOCK_S.
  - Mismatch with `fail_cnt`+1 < MAX_TRIES: `fail_cnt`++, go to LOCKOUT, load `timer_sec`<=LOCKOUT_S.
  - Mismatch with `fail_cnt`+1 == MAX_TRIES: `fail_cnt`++, go to ALARM, `timer_sec`<=0.
  - W compares even when `buf_empty`=1; empty compares as 0.
- OPEN:
  - Any key strobe reloads `timer_sec`<=RELOCK_S and clears the prescaler.
  - Y: go to SECURE, `timer_sec`<=0.
  - W with `buf_empty`=0: passphrase<=`buf_data` (code change), stay in OPEN.
  - Timer expiry: go to SECURE.
- LOCKOUT:
  - All strobes are ignored.
  - Timer expiry: go to SECURE; `fail_cnt` is retained.
- ALARM: terminal. All strobes are ignored and only `reset` exits.
- Timer:
  - Loading a value also clears the prescaler.
  - In OPEN and LOCKOUT the prescaler counts every cycle.
  - At prescaler==TICKS_PER_S-1 the prescaler wraps to 0 and `timer_sec` decrements.
  - Expiry is that wrap cycle with `timer_sec`==1. The state change and `timer_sec`<=0 take effect on the same edge.
  - In other states the prescaler is held at 0.
- X, Z and digits never change controller state, except the OPEN timer reload.

## Timing
- Strobe sampled at edge N: `state`, passphrase, `fail_cnt`, `timer_sec` update at edge N. `buf_clr` is high for the cycle after edge N only.
- Dwell:
  - LOCKOUT lasts exactly LOCKOUT_S×TICKS_PER_S cycles from the entry edge to the exit edge.
  - OPEN idle relock takes RELOCK_S×TICKS_PER_S cycles after the last strobe.
- OPEN key strobe on the expiry cycle: the strobe wins.
  - Y goes to SECURE.
  - Any other key reloads the timer and stays in OPEN.
- `reset` is honoured on any cycle, including mid-countdown, and overrides a coincident strobe.
- Back-to-back strobes on consecutive cycles are each processed.

## Test plan
Override parameters TICKS_PER_S=4, LOCKOUT_S=2, RELOCK_S=3, MAX_TRIES=3.
- Set code:
  - Stimulus: reset, then W with `buf_data`=0x1234, `buf_empty`=0.
  - Response: `state` 0->1 next edge, `buf_clr` high one cycle.
  - Follow-up: W with 0x1234 gives `state`=2, `timer_sec`=3.
- Empty enter:
  - Stimulus: in INIT, W with `buf_empty`=1.
  - Response: `state` stays 0, no `buf_clr`.
- Lockout:
  - Stimulus: in SECURE, W with 0x9999.
  - Response: `state`=4, `fail_cnt`=1, `timer_sec`=2.
  - Strobes during lockout are ignored.
  - Return to `state`=1 exactly 8 cycles after entry.
- Alarm:
  - Stimulus: three wrong W compares, waiting out each lockout.
  - Response: `state`=3, `fail_cnt`=3, `buf_en`=0.
  - A correct W afterwards does nothing; reset restores INIT.
- Auto-relock:
  - Stimulus: in OPEN, no keys for 12 cycles.
  - Response: `state`=1 and a `buf_clr` pulse.
  - Digit strobe at cycle 11: timer reloads to 3 and relock moves to 12 cycles later.
- Code change and mid-run reset:
  - Stimulus: in OPEN, W with 0x55, then Y.
  - Response: SECURE; 0x55 opens and 0x1234 fails.
  - Reset during LOCKOUT: all outputs return to reset values the next edge.
